// File: rtl/vpe_pkg.sv
// Shared VPE definitions: instruction word width, icache geometry, instruction type.
package vpe_pkg;

    localparam int unsigned VPE_INSTR_W      = 12;
    localparam int unsigned VPE_ICACHE_AW    = 8;
    localparam int unsigned VPE_ICACHE_DEPTH = 1 << VPE_ICACHE_AW;

    typedef logic [VPE_INSTR_W-1:0] vpe_instr_t;

endpackage : vpe_pkg

// File: rtl/vpe_icache_if.sv
// Write/read port bundle of the VPE instruction cache.
//   master : controller + sequencer side (drives i_*, observes o_*)
//   slave  : icache side
//   i_data/i_wr_valid/i_wr_addr : write port
//   i_rd_valid/i_rd_addr        : read request
//   o_data/o_rd_valid/o_rd_hit  : registered read response
interface vpe_icache_if
    import vpe_pkg::*;
#(
    parameter int unsigned DATA_W = VPE_INSTR_W,
    parameter int unsigned ADDR_W = VPE_ICACHE_AW
);

    logic [DATA_W-1:0] i_data;
    logic              i_wr_valid;
    logic [ADDR_W-1:0] i_wr_addr;
    logic              i_rd_valid;
    logic [ADDR_W-1:0] i_rd_addr;
    logic [DATA_W-1:0] o_data;
    logic              o_rd_valid;
    logic              o_rd_hit;

    modport master (
        output i_data, i_wr_valid, i_wr_addr, i_rd_valid, i_rd_addr,
        input  o_data, o_rd_valid, o_rd_hit
    );

    modport slave (
        input  i_data, i_wr_valid, i_wr_addr, i_rd_valid, i_rd_addr,
        output o_data, o_rd_valid, o_rd_hit
    );

endinterface : vpe_icache_if

// File: rtl/vpe_icache.sv
// VPE instruction store: DEPTH x DATA_W synchronous-write, registered-read memory
// with per-entry valid bits.
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset (clears outputs and valid bits, not storage)
//   bus   : vpe_icache_if.slave (write port, read request, registered read response)
module vpe_icache
    import vpe_pkg::*;
#(
    parameter int unsigned DATA_W = VPE_INSTR_W,
    parameter int unsigned ADDR_W = VPE_ICACHE_AW,
    parameter int unsigned DEPTH  = 1 << ADDR_W
) (
    input  logic               clk,
    input  logic               rst_n,
    vpe_icache_if.slave        bus
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [DEPTH-1:0]  valid_d,    valid_q;
    logic [DATA_W-1:0] data_d,     data_q;
    logic              hit_d,      hit_q;
    logic              rd_valid_d, rd_valid_q;

    // Storage array is intentionally not reset; valid bits gate its contents.
    always_ff @(posedge clk) begin
        if (bus.i_wr_valid) begin
            mem_q[bus.i_wr_addr] <= bus.i_data;
        end
    end

    // Next-state: valid bit set on write; read response with write-first bypass.
    always_comb begin
        valid_d    = valid_q;
        data_d     = data_q;
        hit_d      = hit_q;
        rd_valid_d = bus.i_rd_valid;

        if (bus.i_wr_valid) begin
            valid_d[bus.i_wr_addr] = 1'b1;
        end

        if (bus.i_rd_valid) begin
            if (bus.i_wr_valid && (bus.i_wr_addr == bus.i_rd_addr)) begin
                data_d = bus.i_data;
                hit_d  = 1'b1;
            end else if (valid_q[bus.i_rd_addr]) begin
                data_d = mem_q[bus.i_rd_addr];
                hit_d  = 1'b1;
            end else begin
                data_d = '0;
                hit_d  = 1'b0;
            end
        end
    end

    // Control/response registers; reset drops any in-flight read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= '0;
            data_q     <= '0;
            hit_q      <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            data_q     <= data_d;
            hit_q      <= hit_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign bus.o_data     = data_q;
    assign bus.o_rd_hit   = hit_q;
    assign bus.o_rd_valid = rd_valid_q;

endmodule : vpe_icache

// File: tb/tb_vpe_icache.sv
// Directed, table-driven bench for vpe_icache plus hand-written reset sequences.
module tb_vpe_icache;
    import vpe_pkg::*;

    logic clk;
    logic rst_n;

    vpe_icache_if bus ();

    vpe_icache u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       wr;
        logic [7:0] wa;
        vpe_instr_t wd;
        logic       rd;
        logic [7:0] ra;
        logic       ev;
        logic       eh;
        vpe_instr_t ed;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    function automatic void add(input logic wr, input logic [7:0] wa, input vpe_instr_t wd,
                                input logic rd, input logic [7:0] ra,
                                input logic ev, input logic eh, input vpe_instr_t ed);
        vec_t v;
        v.wr = wr; v.wa = wa; v.wd = wd; v.rd = rd; v.ra = ra;
        v.ev = ev; v.eh = eh; v.ed = ed;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic ev, input logic eh, input vpe_instr_t ed);
        chk({tag, ".rd_valid"}, 32'(bus.o_rd_valid), 32'(ev));
        chk({tag, ".hit"},      32'(bus.o_rd_hit),   32'(eh));
        chk({tag, ".data"},     32'(bus.o_data),     32'(ed));
    endtask

    // Drive one vector at negedge, check the registered response just after the next posedge.
    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        bus.i_wr_valid = v.wr;
        bus.i_wr_addr  = v.wa;
        bus.i_data     = v.wd;
        bus.i_rd_valid = v.rd;
        bus.i_rd_addr  = v.ra;
        @(posedge clk);
        #1;
        chk_out(tag, v.ev, v.eh, v.ed);
    endtask

    task automatic idle_inputs();
        bus.i_wr_valid = 1'b0;
        bus.i_wr_addr  = '0;
        bus.i_data     = '0;
        bus.i_rd_valid = 1'b0;
        bus.i_rd_addr  = '0;
    endtask

    initial begin
        vec_t v;
        rst_n = 1'b0;
        idle_inputs();

        // Writes 0..9 with data 1..10; outputs still at reset values.
        for (int i = 0; i < 10; i++) add(1'b1, 8'(i), 12'(i + 1), 1'b0, 8'h00, 1'b0, 1'b0, 12'h000);
        // Back-to-back reads 0..9.
        for (int i = 0; i < 10; i++) add(1'b0, 8'h00, 12'h000, 1'b1, 8'(i), 1'b1, 1'b1, 12'(i + 1));
        add(1'b0, 8'h00, 12'h000, 1'b1, 8'd10,  1'b1, 1'b0, 12'h000); // never written
        add(1'b0, 8'h00, 12'h000, 1'b0, 8'd0,   1'b0, 1'b0, 12'h000); // idle: hold
        add(1'b1, 8'd5,  12'hABC, 1'b1, 8'd5,   1'b1, 1'b1, 12'hABC); // same-address bypass
        add(1'b0, 8'h00, 12'h000, 1'b0, 8'd0,   1'b0, 1'b1, 12'hABC); // idle: hold
        add(1'b0, 8'h00, 12'h000, 1'b1, 8'd5,   1'b1, 1'b1, 12'hABC); // re-read 5
        add(1'b1, 8'd255,12'hFFF, 1'b0, 8'd0,   1'b0, 1'b1, 12'hABC); // write top entry
        add(1'b0, 8'h00, 12'h000, 1'b1, 8'd255, 1'b1, 1'b1, 12'hFFF);
        add(1'b1, 8'd1,  12'h777, 1'b1, 8'd0,   1'b1, 1'b1, 12'h001); // read 0 while writing 1
        add(1'b0, 8'h00, 12'h000, 1'b1, 8'd1,   1'b1, 1'b1, 12'h777);
        add(1'b1, 8'd20, 12'h123, 1'b1, 8'd3,   1'b1, 1'b1, 12'h004); // independent rd/wr
        add(1'b0, 8'h00, 12'h000, 1'b1, 8'd20,  1'b1, 1'b1, 12'h123);

        // Reset then idle.
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_out("reset_idle", 1'b0, 1'b0, 12'h000);

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("vec%0d", i));

        // Async reset clears a visible response immediately.
        v = '{wr: 1'b0, wa: 8'h00, wd: 12'h000, rd: 1'b1, ra: 8'd3, ev: 1'b1, eh: 1'b1, ed: 12'h004};
        apply(v, "pre_rst_read");
        rst_n = 1'b0;
        #1;
        chk_out("async_rst", 1'b0, 1'b0, 12'h000);
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;

        // Reset asserted between a read request and its response edge.
        @(negedge clk);
        bus.i_rd_valid = 1'b1;
        bus.i_rd_addr  = 8'd0;
        #2;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk_out("rst_inflight", 1'b0, 1'b0, 12'h000);
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;

        v = '{wr: 1'b0, wa: 8'h00, wd: 12'h000, rd: 1'b1, ra: 8'd0, ev: 1'b1, eh: 1'b0, ed: 12'h000};
        apply(v, "post_rst_rd0");
        v = '{wr: 1'b0, wa: 8'h00, wd: 12'h000, rd: 1'b1, ra: 8'd5, ev: 1'b1, eh: 1'b0, ed: 12'h000};
        apply(v, "post_rst_rd5");
        v = '{wr: 1'b1, wa: 8'd7, wd: 12'h5A5, rd: 1'b0, ra: 8'd0, ev: 1'b0, eh: 1'b0, ed: 12'h000};
        apply(v, "post_rst_wr7");
        v = '{wr: 1'b0, wa: 8'h00, wd: 12'h000, rd: 1'b1, ra: 8'd7, ev: 1'b1, eh: 1'b1, ed: 12'h5A5};
        apply(v, "post_rst_rd7");

        @(negedge clk);
        idle_inputs();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_vpe_icache
